projectile_unit: RTL

One projectile slot fed by the ball/fire controller. The block accepts a one-cycle fire strobe and a one-hot direction from the controller, and latches a launch point from the shooter's position. It then steps the projectile once per video frame until the projectile leaves the playfield or a hit is reported. It drives `done` back to the controller to mark the slot free, and exposes the projectile position to the sprite/colour mapper. Two instances sit side by side, one per `select` bit.

---
 rtl/projectile_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/projectile_unit.sv
// projectile_unit
//   One projectile slot. A one-cycle fire strobe latches a launch point and a
//   direction; the projectile then steps STEP pixels per frame tick until it
//   would cross the edge clearance band or a hit is reported, then frees the
//   slot again.
//
// Ports
//   Clk, Reset         system clock, synchronous active-high reset
//   frame_clk          frame signal, rising edge gives one move opportunity
//   fire, direction    launch strobe and one-hot direction (up/down/right/left)
//   origin_x/origin_y  launch point
//   hit                collision report, retires the projectile
//   done               slot idle, may be fired
//   active             projectile visible and moving
//   ball_x/ball_y      current projectile position
module projectile_unit #(
    parameter int STEP  = 4,
    parameter int SIZE  = 4,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [3:0] direction,
    input  logic [9:0] origin_x,
    input  logic [9:0] origin_y,
    input  logic       hit,
    output logic       done,
    output logic       active,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y
);

    typedef enum logic [1:0] {S_IDLE, S_FLY, S_RETIRE} state_t;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] LIM_LO  = 11'(SIZE + STEP);
    localparam logic [10:0] LIM_XHI = 11'(X_MAX - SIZE);
    localparam logic [10:0] LIM_YHI = 11'(Y_MAX - SIZE);

    state_t     state, state_nxt;
    logic       fc_q;
    logic       tick;
    logic [3:0] dir_q;
    logic [3:0] dir_new;
    logic       launch;
    logic       edge_exit;
    logic [9:0] nx, ny;
    logic [10:0] x_ext, y_ext;

    // fc_q resets high so a frame_clk already high at release is not a tick
    always_ff @(posedge Clk) begin
        if (Reset) fc_q <= 1'b1;
        else       fc_q <= frame_clk;
    end

    assign tick   = frame_clk & ~fc_q;
    assign launch = fire & (|direction);

    // Multi-bit direction collapses to one-hot: right > left > down > up
    always_comb begin
        dir_new = DIR_UP;
        if      (direction[2]) dir_new = DIR_RIGHT;
        else if (direction[3]) dir_new = DIR_LEFT;
        else if (direction[1]) dir_new = DIR_DOWN;
    end

    // Move evaluation in 11 bits so left/up never wrap below zero
    assign x_ext = {1'b0, ball_x};
    assign y_ext = {1'b0, ball_y};

    always_comb begin
        edge_exit = 1'b0;
        nx        = ball_x;
        ny        = ball_y;
        case (dir_q)
            DIR_RIGHT: begin
                edge_exit = (x_ext + STEP11) > LIM_XHI;
                nx        = ball_x + 10'(STEP);
            end
            DIR_LEFT: begin
                edge_exit = x_ext < LIM_LO;
                nx        = ball_x - 10'(STEP);
            end
            DIR_DOWN: begin
                edge_exit = (y_ext + STEP11) > LIM_YHI;
                ny        = ball_y + 10'(STEP);
            end
            default: begin
                edge_exit = y_ext < LIM_LO;
                ny        = ball_y - 10'(STEP);
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state; hit outranks tick in flight
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (launch) state_nxt = S_FLY;
            S_FLY: begin
                if (hit)                    state_nxt = S_RETIRE;
                else if (tick && edge_exit) state_nxt = S_RETIRE;
            end
            S_RETIRE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        done   = (state == S_IDLE);
        active = (state == S_FLY);
    end

    // Position / direction datapath
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ball_x <= '0;
            ball_y <= '0;
            dir_q  <= DIR_UP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        ball_x <= origin_x;
                        ball_y <= origin_y;
                        dir_q  <= dir_new;
                    end
                end
                S_FLY: begin
                    if (!hit && tick && !edge_exit) begin
                        ball_x <= nx;
                        ball_y <= ny;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
